rgbw_stream_conv: RTL and testbench

RGBW_STREAM_CONV -- requirements
Module: rgbw_stream_conv

---
 rtl/rgbw_stream_conv.sv | 168 ++++++++++++++++
 tb/tb_rgbw_stream_conv.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgbw_stream_conv.sv
// ---------------------------------------------------------------------------
// rgbw_stream_conv
//   Converts a {G,R,B} pixel stream into {G,R,B,W} through a 3-stage pipeline:
//     stage 1 : register the input beat and its conversion mode
//     stage 2 : W = min(R,G,B)
//     stage 3 : apply the mode and drive the out_* registers
//   Stream-reset markers travel through the same pipeline in order and leave
//   as out_stream_reset=1 with out_word=0. Each stage moves only when the
//   output register is empty or being drained. This single advance signal is
//   also in_ready.
//
//   Modes: 0 pass (W=0), 1 extract (RGB-min, W=min), 2 boost (RGB, W=min),
//          3 scaled (RGB-min, W=sat((min*WSCALE)>>8)).
//
//   Configuration macro: RGBW_CONV_PIXCOUNT_EN
//     defined   : pix_count counts data beats emitted since the last marker
//     undefined : pix_count is tied to 0 and no counter is built
//
// Parameters
//   CW      bits per colour component
//   WSCALE  white gain for mode 3, Q8 (256 = 1.0)
// Ports
//   clk               pipeline clock (96 MHz PLL clock in the system)
//   rst               synchronous active-high reset
//   in_valid/in_ready input handshake
//   in_word           {G,R,B}, G in the MSBs
//   in_stream_reset   beat is a stream-reset marker (in_word ignored)
//   mode              conversion mode, bound to the beat when it is accepted
//   out_valid/out_ready output handshake
//   out_word          {G,R,B,W}, G in the MSBs
//   out_stream_reset  output beat is a marker
//   pix_count         data beats emitted since the last marker (saturating)
// ---------------------------------------------------------------------------
module rgbw_stream_conv #(
    parameter int CW     = 8,
    parameter int WSCALE = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3*CW-1:0] in_word,
    input  logic            in_stream_reset,
    input  logic [1:0]      mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4*CW-1:0] out_word,
    output logic            out_stream_reset,
    output logic [15:0]     pix_count
);

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_EXTRACT = 2'd1,
        MODE_BOOST   = 2'd2,
        MODE_SCALED  = 2'd3
    } mode_e;

    localparam int PW = CW + 32;
    localparam logic [PW-1:0] CMAX = {{32{1'b0}}, {CW{1'b1}}};

    logic advance;

    // stage 1
    logic          s1_valid, s1_marker;
    logic [CW-1:0] s1_g, s1_r, s1_b;
    mode_e         s1_mode;

    // stage 2
    logic          s2_valid, s2_marker;
    logic [CW-1:0] s2_g, s2_r, s2_b, s2_min;
    mode_e         s2_mode;

    // combinational helpers
    logic [CW-1:0]   min_rgb;
    logic [PW-1:0]   scale_prod;
    logic [PW-1:0]   scale_shr;
    logic [CW-1:0]   w_scaled;
    logic [4*CW-1:0] out_word_next;

    // The whole pipeline moves as one unit. It advances whenever the output
    // register is empty or is being drained this cycle.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        min_rgb = s1_g;
        if (s1_r < min_rgb) min_rgb = s1_r;
        if (s1_b < min_rgb) min_rgb = s1_b;
    end

    // Scale the white level in a wide product so that large WSCALE values
    // cannot wrap before the saturation compare.
    assign scale_prod = PW'(s2_min) * PW'(WSCALE);
    assign scale_shr  = scale_prod >> 8;
    assign w_scaled   = (scale_shr > CMAX) ? {CW{1'b1}} : scale_shr[CW-1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        out_word_next = '0;
        if (s2_valid && !s2_marker) begin
            unique case (s2_mode)
                MODE_PASS:    out_word_next = {s2_g, s2_r, s2_b, {CW{1'b0}}};
                MODE_EXTRACT: out_word_next = {s2_g - s2_min, s2_r - s2_min,
                                               s2_b - s2_min, s2_min};
                MODE_BOOST:   out_word_next = {s2_g, s2_r, s2_b, s2_min};
                MODE_SCALED:  out_word_next = {s2_g - s2_min, s2_r - s2_min,
                                               s2_b - s2_min, w_scaled};
                default:      out_word_next = '0;
            endcase
        end
    end

    // Control path: valids and visible outputs are reset. A reset drops
    // every in-flight beat, and in_valid is ignored while rst is high.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so all stages see pre-edge values.
        if (rst) begin
            s1_valid         <= 1'b0;
            s2_valid         <= 1'b0;
            out_valid        <= 1'b0;
            out_word         <= '0;
            out_stream_reset <= 1'b0;
        end else if (advance) begin
            s1_valid         <= in_valid;
            s2_valid         <= s1_valid;
            out_valid        <= s2_valid;
            out_word         <= out_word_next;
            out_stream_reset <= s2_valid && s2_marker;
        end
    end

    // Data path: qualified by the stage valids, so it needs no reset.
    always_ff @(posedge clk) begin
        // NOTE: payload registers are left unreset on purpose; only the valid bits need a known state.
        if (advance) begin
            s1_marker <= in_stream_reset;
            s1_g      <= in_word[3*CW-1:2*CW];
            s1_r      <= in_word[2*CW-1:CW];
            s1_b      <= in_word[CW-1:0];
            s1_mode   <= mode_e'(mode);
            s2_marker <= s1_marker;
            s2_g      <= s1_g;
            s2_r      <= s1_r;
            s2_b      <= s1_b;
            s2_min    <= min_rgb;
            s2_mode   <= s1_mode;
        end
    end

`ifdef RGBW_CONV_PIXCOUNT_EN
    // A marker and a data beat never share a handshake. The marker clears
    // the count, and each data beat adds one up to 16'hFFFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_count <= '0;
        end else if (out_valid && out_ready) begin
            if (out_stream_reset)
                pix_count <= '0;
            else if (pix_count != 16'hFFFF)
                pix_count <= pix_count + 16'd1;
        end
    end
`else
    assign pix_count = '0;
`endif

endmodule

// File: tb/tb_rgbw_stream_conv.sv
// ---------------------------------------------------------------------------
// tb_rgbw_stream_conv
//   Scoreboard bench for rgbw_stream_conv (CW=8, WSCALE=512).
//   A negedge monitor does three things:
//     - It pushes the expected output of every accepted input beat into a
//       queue. The expected value comes from a plain arithmetic model of the
//       conversion rules.
//     - It pops and compares on every output handshake, including the exact
//       latency: 3 clocks plus the stall cycles seen in between.
//     - It checks the ready rule, output stability under stall, pix_count,
//       and the state just after reset.
//   Directed sequences cover the named cases. A randomized phase follows
//   them.
// ---------------------------------------------------------------------------
module tb_rgbw_stream_conv;

    localparam int CW     = 8;
    localparam int WSCALE = 512;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3*CW-1:0] in_word;
    logic            in_stream_reset;
    logic [1:0]      mode;
    logic            out_valid;
    logic            out_ready;
    logic [4*CW-1:0] out_word;
    logic            out_stream_reset;
    logic [15:0]     pix_count;

    always #5 clk = ~clk;

    rgbw_stream_conv #(.CW(CW), .WSCALE(WSCALE)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_word          (in_word),
        .in_stream_reset  (in_stream_reset),
        .mode             (mode),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_word         (out_word),
        .out_stream_reset (out_stream_reset),
        .pix_count        (pix_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the conversion rules written as integer arithmetic.
    function automatic logic [31:0] model(input logic [23:0] w, input logic [1:0] md);
        int g, r, b, mn, ws;
        g  = int'(w[23:16]);
        r  = int'(w[15:8]);
        b  = int'(w[7:0]);
        mn = g;
        if (r < mn) mn = r;
        if (b < mn) mn = b;
        ws = (mn * WSCALE) / 256;
        if (ws > 255) ws = 255;
        case (md)
            2'd0:    return {8'(g), 8'(r), 8'(b), 8'd0};
            2'd1:    return {8'(g - mn), 8'(r - mn), 8'(b - mn), 8'(mn)};
            2'd2:    return {8'(g), 8'(r), 8'(b), 8'(mn)};
            default: return {8'(g - mn), 8'(r - mn), 8'(b - mn), 8'(ws)};
        endcase
    endfunction

    typedef struct {
        logic [31:0] word;
        logic        marker;
        int          acc_cycle;
        int          acc_stalls;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          cycle = 0;
    int          stalls = 0;
    int          pix_exp = 0;
    logic        saw_rst = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word;
    logic        prev_mark;

    // Monitor and scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pix_exp    = 0;
            saw_rst    = 1'b1;
            prev_stall = 1'b0;
        end else begin
            if (saw_rst) begin
                check("post_rst_out_valid", 64'(out_valid), 64'(0));
                check("post_rst_pix_count", 64'(pix_count), 64'(0));
                check("post_rst_in_ready", 64'(in_ready), 64'(1));
                saw_rst = 1'b0;
            end
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (prev_stall) begin
                check("stall_out_valid", 64'(out_valid), 64'(1));
                check("stall_out_word", 64'(out_word), 64'(prev_word));
                check("stall_out_marker", 64'(out_stream_reset), 64'(prev_mark));
            end
            check("pix_count", 64'(pix_count), 64'(pix_exp));
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %0h with empty scoreboard (t=%0t)",
                             out_word, $time);
                end else begin
                    cur = exp_q.pop_front();
                    if (out_word !== cur.word || out_stream_reset !== cur.marker) begin
                        errors++;
                        $display("FAIL out_beat: got %0h/%0b expected %0h/%0b (t=%0t)",
                                 out_word, out_stream_reset, cur.word, cur.marker, $time);
                    end
                    check("latency", 64'(cycle - cur.acc_cycle),
                          64'(3 + stalls - cur.acc_stalls));
                end
`ifdef RGBW_CONV_PIXCOUNT_EN
                if (out_stream_reset) pix_exp = 0;
                else if (pix_exp < 16'hFFFF) pix_exp = pix_exp + 1;
`endif
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = out_word;
            prev_mark  = out_stream_reset;
            if (!in_ready) stalls++;
            if (in_valid && in_ready) begin
                cur.marker     = in_stream_reset;
                cur.word       = in_stream_reset ? 32'h0 : model(in_word, mode);
                cur.acc_cycle  = cycle;
                cur.acc_stalls = stalls;
                exp_q.push_back(cur);
            end
        end
        cycle++;
    end

    // Drivers: all changes happen #1 after the rising edge.
    task automatic idle();
        in_valid        = 1'b0;
        in_stream_reset = 1'b0;
    endtask

    task automatic send(input logic [23:0] w, input logic [1:0] md, input logic mk);
        bit done;
        done            = 1'b0;
        in_valid        = 1'b1;
        in_word         = w;
        mode            = md;
        in_stream_reset = mk;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready in 200 clks, required accept");
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_out(input string name, input logic [31:0] w);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                check(name, 64'(out_word), 64'(w));
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: got no output in 50 clks, required %0h", name, w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        idle();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_marker();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_stream_reset) begin
`ifdef RGBW_CONV_PIXCOUNT_EN
                check("marker_pix_before", 64'(pix_count), 64'(3));
`endif
                check("marker_out_word", 64'(out_word), 64'(0));
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL marker_timeout: got no marker in 50 clks, required one");
        end
        @(negedge clk);
        check("marker_pix_after", 64'(pix_count), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        in_valid        = 1'b0;
        in_word         = '0;
        in_stream_reset = 1'b0;
        mode            = 2'd0;
        out_ready       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Mode 1 extract, exact 3-clock latency through the scoreboard.
        send(24'h40_80_20, 2'd1, 1'b0);
        expect_out("extract_word", 32'h20_60_00_20);
        drain();

        // Mode 3 with WSCALE=512 saturates W.
        send(24'hFF_FF_FF, 2'd3, 1'b0);
        expect_out("scaled_sat_word", 32'h00_00_00_FF);
        drain();

        // Mode toggles 0 -> 2 between consecutive beats.
        send(24'h10_20_30, 2'd0, 1'b0);
        send(24'h10_20_30, 2'd2, 1'b0);
        expect_out("mode0_word", 32'h10_20_30_00);
        expect_out("mode2_word", 32'h10_20_30_10);
        drain();

        // Three data beats, then a marker.
        do_reset();
        for (int i = 0; i < 3; i++) send(24'(32'h112233 * (i + 1)), 2'(i), 1'b0);
        send(24'hABCDEF, 2'd1, 1'b1);
        wait_marker();
        drain();

        // Five back-to-back beats with a 4-clock output stall mid-stream.
        fork
            begin
                for (int i = 0; i < 5; i++) send(24'($urandom), 2'($urandom), 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight: nothing stale may emerge.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(24'($urandom), 2'($urandom), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure and rare resets.
        for (int i = 0; i < 1500; i++) begin
            in_valid        = ($urandom_range(0, 3) != 0);
            in_stream_reset = ($urandom_range(0, 15) == 0);
            in_word         = 24'($urandom);
            mode            = 2'($urandom);
            out_ready       = ($urandom_range(0, 3) != 0);
            rst             = ($urandom_range(0, 499) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
